// File: rtl/opb_reg_bank_pkg.sv
// Shared definitions for the OPB register bank: slave FSM states, CTRL
// register bit positions (numeric LSB-0 view of the big-endian OPB bus),
// word offsets and the channel count limit.
package opb_reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } ack_state_e;

  // OPB DBus[31] is numeric bit 0, DBus[30] is numeric bit 1.
  localparam int CTRL_SNAP_BIT  = 0;
  localparam int CTRL_LIVE_BIT  = 1;
  // snap_count occupies OPB bits [0:15], i.e. numeric bits [31:16].
  localparam int CTRL_COUNT_LSB = 16;

  localparam int WORD_CTRL    = 0;
  localparam int WORD_CH0     = 1;
  localparam int MAX_CHANNELS = 16;

  // CTRL/STATUS read value in numeric (LSB-0) order.
  function automatic logic [31:0] ctrl_word(input logic [15:0] cnt, input logic live);
    logic [31:0] w;
    w = '0;
    w[CTRL_COUNT_LSB +: 16] = cnt;
    w[CTRL_LIVE_BIT]        = live;
    return w;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode and acknowledge sequencer. Produces a one-cycle
// accept strobe on the hit cycle and a single-cycle ack in the following
// cycle; a master that keeps select asserted is parked in HOLD so the same
// access is never acknowledged twice.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for a select with an address inside the bank
// ST_ACK  | Sl_xferAck asserted for exactly this cycle
// ST_HOLD | access done, waiting for the master to drop select
module opb_slave_ack_fsm
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h010B0100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010B01FF,
  parameter int          C_OPB_AWIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [C_OPB_AWIDTH-1:0] i_abus,
  input  logic                    i_select,
  output logic                    o_accept,
  output logic                    o_ack
);

  ack_state_e r_state;
  ack_state_e w_state_nxt;
  logic       w_hit;

  assign w_hit = i_select &&
                 (i_abus >= C_OPB_AWIDTH'(C_BASEADDR)) &&
                 (i_abus <= C_OPB_AWIDTH'(C_HIGHADDR));

  // State register; reset aborts any access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    o_accept    = 1'b0;
    o_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          o_accept    = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        o_ack       = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!i_select) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB slave register bank exposing C_NUM_CHANNELS 32-bit user channels to the
// PPC. Word 0 is CTRL/STATUS (snapshot request, live-mode, snapshot counter);
// words 1..C_NUM_CHANNELS read either the last snapshot or the live inputs.
// Optional feature macro: OPB_REG_BANK_TIMESTAMP_EN adds a free-running cycle
// counter captured at each snapshot, readable at word C_NUM_CHANNELS+1.
module opb_register_bank_simulink2ppc
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR     = 32'h010B0100,
  parameter logic [31:0] C_HIGHADDR     = 32'h010B01FF,
  parameter int          C_OPB_AWIDTH   = 32,
  parameter int          C_OPB_DWIDTH   = 32,
  parameter int          C_NUM_CHANNELS = 4
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:3]                  OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  input  logic [32*C_NUM_CHANNELS-1:0] user_data_in,
  output logic                        snap_strobe
);

  localparam int WORD_W = C_OPB_AWIDTH - 2;

  // Numeric (LSB-0) views of the big-endian bus fields.
  logic [C_OPB_AWIDTH-1:0] w_abus;
  logic [C_OPB_DWIDTH-1:0] w_dbus;
  logic [3:0]              w_be;
  logic [C_OPB_AWIDTH-1:0] w_offset;
  logic [WORD_W-1:0]       w_word;

  assign w_abus   = OPB_ABus;
  assign w_dbus   = OPB_DBus;
  assign w_be     = OPB_BE;
  assign w_offset = w_abus - C_OPB_AWIDTH'(C_BASEADDR);
  assign w_word   = w_offset[C_OPB_AWIDTH-1:2];

  logic w_accept;
  logic w_ack;

  opb_slave_ack_fsm #(
    .C_BASEADDR  (C_BASEADDR),
    .C_HIGHADDR  (C_HIGHADDR),
    .C_OPB_AWIDTH(C_OPB_AWIDTH)
  ) u_ack_fsm (
    .i_clk   (OPB_Clk),
    .i_rst_n (OPB_Rst_n),
    .i_abus  (w_abus),
    .i_select(OPB_select),
    .o_accept(w_accept),
    .o_ack   (w_ack)
  );

  // Access captured on the hit cycle, consumed during ACK.
  logic                    r_rnw;
  logic [WORD_W-1:0]       r_word;
  logic                    r_be_lsb;
  logic                    r_wsnap;
  logic                    r_wlive;
  logic [C_OPB_DWIDTH-1:0] r_rdata;

  // Bank state.
  logic [31:0] r_snap [C_NUM_CHANNELS];
  logic [15:0] r_snap_count;
  logic        r_live;
  logic        r_snap_strobe;

`ifdef OPB_REG_BANK_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_ts_snap;
`endif

  logic                    w_ctrl_wr;
  logic                    w_snap_take;
  logic [C_OPB_DWIDTH-1:0] w_rd_val;

  // A CTRL write only takes effect when the least significant byte lane is
  // enabled; it commits at the end of the ACK cycle so a reset during ACK
  // discards it.
  assign w_ctrl_wr   = w_ack && !r_rnw && (r_word == WORD_W'(WORD_CTRL)) && r_be_lsb;
  assign w_snap_take = w_ctrl_wr && r_wsnap;

  // Read mux evaluated against the address presented on the hit cycle, so
  // live-mode reads see user_data_in as it was at the hit.
  always_comb begin
    w_rd_val = '0;
    if (w_word == WORD_W'(WORD_CTRL)) begin
      w_rd_val = C_OPB_DWIDTH'(ctrl_word(r_snap_count, r_live));
    end
    for (int k = 0; k < C_NUM_CHANNELS; k++) begin
      if (w_word == WORD_W'(WORD_CH0 + k)) begin
        w_rd_val = r_live ? C_OPB_DWIDTH'(user_data_in[32*k +: 32])
                          : C_OPB_DWIDTH'(r_snap[k]);
      end
    end
`ifdef OPB_REG_BANK_TIMESTAMP_EN
    if (w_word == WORD_W'(WORD_CH0 + C_NUM_CHANNELS)) begin
      w_rd_val = r_live ? C_OPB_DWIDTH'(r_ts) : C_OPB_DWIDTH'(r_ts_snap);
    end
`endif
  end

  // Latch the access attributes and read data when the FSM accepts a hit.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_rnw    <= 1'b0;
      r_word   <= '0;
      r_be_lsb <= 1'b0;
      r_wsnap  <= 1'b0;
      r_wlive  <= 1'b0;
      r_rdata  <= '0;
    end else if (w_accept) begin
      r_rnw    <= OPB_RNW;
      r_word   <= w_word;
      r_be_lsb <= w_be[0];
      r_wsnap  <= w_dbus[CTRL_SNAP_BIT];
      r_wlive  <= w_dbus[CTRL_LIVE_BIT];
      r_rdata  <= w_rd_val;
    end
  end

  // Snapshot capture, snapshot counter, strobe and live-mode bit.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int k = 0; k < C_NUM_CHANNELS; k++) r_snap[k] <= '0;
      r_snap_count  <= '0;
      r_live        <= 1'b0;
      r_snap_strobe <= 1'b0;
    end else begin
      r_snap_strobe <= w_snap_take;
      if (w_snap_take) begin
        for (int k = 0; k < C_NUM_CHANNELS; k++) r_snap[k] <= user_data_in[32*k +: 32];
        r_snap_count <= r_snap_count + 16'd1;
      end
      if (w_ctrl_wr) r_live <= r_wlive;
    end
  end

`ifdef OPB_REG_BANK_TIMESTAMP_EN
  // Free-running cycle counter, captured alongside the channel snapshot.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_ts      <= '0;
      r_ts_snap <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (w_snap_take) r_ts_snap <= r_ts;
    end
  end
`endif

  assign Sl_xferAck  = w_ack;
  assign Sl_DBus     = (w_ack && r_rnw) ? r_rdata : '0;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign snap_strobe = r_snap_strobe;

  // Bus fields this slave has no use for (burst hint, upper byte lanes).
  logic w_unused;
  assign w_unused = ^{OPB_seqAddr, w_be[3:1], w_dbus[C_OPB_DWIDTH-1:2], w_offset[1:0]};

endmodule
